// File: rtl/defines.sv
// rtl/defines.sv - shared constants and enums for the collision detector
package defines;

    // Frames a collision kind stays masked after it has reported
    localparam int COOLDOWN_FRAMES = 4;
    localparam int COOLDOWN_W      = 3;

    // Collision kinds; the value doubles as the bit index into per-kind vectors
    typedef enum logic [2:0] {
        KIND_OBSTACLE = 3'd0,
        KIND_GOOD     = 3'd1,
        KIND_BAD      = 3'd2,
        KIND_BOTTOM   = 3'd3,
        KIND_CREDIT   = 3'd4
    } kind_t;

    localparam int KIND_NUM = 5;

    // Per-kind channel state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIT  = 2'd1,
        ST_COOL = 2'd2
    } chan_state_t;

endpackage

// File: rtl/collision_channel.sv
// rtl/collision_channel.sv - one collision kind: frame accumulator, cooldown (COLLISION_COOLDOWN_EN), pulse register
module collision_channel
    import defines::*;
#(
    parameter int COOLDOWN_FRAMES = defines::COOLDOWN_FRAMES
) (
    input  logic clk,
    input  logic resetN,
    input  logic sof,
    input  logic pause,
    input  logic level_rst,
    input  logic overlap,
    input  logic allow,
    output logic fire,
    output logic pulse
);

    chan_state_t state_q, state_d;
    logic        acc_q, acc_d;
    logic        pulse_d;

`ifdef COLLISION_COOLDOWN_EN
    localparam logic [COOLDOWN_W-1:0] CD_LOAD = COOLDOWN_W'(COOLDOWN_FRAMES);

    logic [COOLDOWN_W-1:0] cooldown_q, cooldown_d;

    // State, accumulator, cooldown and pulse registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            acc_q      <= 1'b0;
            cooldown_q <= '0;
            pulse      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cooldown_q <= cooldown_d;
            pulse      <= pulse_d;
        end
    end

    // HIT means accumulated and not cooling, so it alone decides a report at the frame boundary
    always_comb begin
        fire       = sof && !level_rst && !pause && (state_q == ST_HIT) && allow;
        acc_d      = acc_q;
        cooldown_d = cooldown_q;
        pulse_d    = 1'b0;
        if (level_rst) begin
            acc_d      = 1'b0;
            cooldown_d = '0;
        end else if (pause) begin
            acc_d      = 1'b0;
        end else if (sof) begin
            acc_d   = overlap;
            pulse_d = fire;
            if (fire) begin
                cooldown_d = CD_LOAD;
            end else if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - 3'd1;
            end
        end else begin
            acc_d = acc_q | overlap;
        end
        if (cooldown_d != '0) begin
            state_d = ST_COOL;
        end else if (acc_d) begin
            state_d = ST_HIT;
        end else begin
            state_d = ST_IDLE;
        end
    end
`else
    logic [COOLDOWN_W-1:0] unused_cooldown_cfg;
    assign unused_cooldown_cfg = COOLDOWN_W'(COOLDOWN_FRAMES);

    // State, accumulator and pulse registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            acc_q   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pulse   <= pulse_d;
        end
    end

    // Without cooldown every frame that saw an overlap reports at its closing boundary
    always_comb begin
        fire    = sof && !level_rst && !pause && (state_q == ST_HIT) && allow;
        acc_d   = acc_q;
        pulse_d = 1'b0;
        if (level_rst || pause) begin
            acc_d = 1'b0;
        end else if (sof) begin
            acc_d   = overlap;
            pulse_d = fire;
        end else begin
            acc_d = acc_q | overlap;
        end
        state_d = acc_d ? ST_HIT : ST_IDLE;
    end
`endif

endmodule

// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - per-frame ball collision pulses, optional cooldown via COLLISION_COOLDOWN_EN
module collision_detector
    import defines::*;
#(
    parameter int COOLDOWN_FRAMES = defines::COOLDOWN_FRAMES
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic pause,
    input  logic reset_level_pulse,
    input  logic ballDrawingRequest,
    input  logic obstacleDrawingRequest,
    input  logic obstacleGoodRequest,
    input  logic obstacleBadRequest,
    input  logic bottomDrawingRequest,
    input  logic creditDrawingRequest,
    output logic collisionBallObstacle,
    output logic collisionBallObstacleGood,
    output logic collisionBallObstacleBad,
    output logic collisionBallBottom,
    output logic collisionBallCredit
);

    logic                frame_seen;
    logic [KIND_NUM-1:0] overlap;
    logic [KIND_NUM-1:0] overlap_gated;
    logic [KIND_NUM-1:0] fire;
    logic [KIND_NUM-1:0] pulse;
    logic                unused_fire;

    assign unused_fire = ^{fire[KIND_GOOD], fire[KIND_BAD], fire[KIND_BOTTOM], fire[KIND_CREDIT]};

    // A partial frame before the first boundary after reset must not produce a report
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_seen <= 1'b0;
        end else if (startOfFrame) begin
            frame_seen <= 1'b1;
        end
    end

    // Per-pixel overlap of the ball with each object, gated until frames are aligned
    always_comb begin
        overlap                = '0;
        overlap[KIND_OBSTACLE] = ballDrawingRequest & obstacleDrawingRequest;
        overlap[KIND_GOOD]     = ballDrawingRequest & obstacleDrawingRequest & obstacleGoodRequest;
        overlap[KIND_BAD]      = ballDrawingRequest & obstacleDrawingRequest & obstacleBadRequest;
        overlap[KIND_BOTTOM]   = ballDrawingRequest & bottomDrawingRequest;
        overlap[KIND_CREDIT]   = ballDrawingRequest & creditDrawingRequest;
        overlap_gated          = overlap & {KIND_NUM{frame_seen | startOfFrame}};
    end

    // Good/bad may only report alongside a plain obstacle report
    collision_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_ch_obstacle (
        .clk       (clk),
        .resetN    (resetN),
        .sof       (startOfFrame),
        .pause     (pause),
        .level_rst (reset_level_pulse),
        .overlap   (overlap_gated[KIND_OBSTACLE]),
        .allow     (1'b1),
        .fire      (fire[KIND_OBSTACLE]),
        .pulse     (pulse[KIND_OBSTACLE])
    );

    collision_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_ch_good (
        .clk       (clk),
        .resetN    (resetN),
        .sof       (startOfFrame),
        .pause     (pause),
        .level_rst (reset_level_pulse),
        .overlap   (overlap_gated[KIND_GOOD]),
        .allow     (fire[KIND_OBSTACLE]),
        .fire      (fire[KIND_GOOD]),
        .pulse     (pulse[KIND_GOOD])
    );

    collision_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_ch_bad (
        .clk       (clk),
        .resetN    (resetN),
        .sof       (startOfFrame),
        .pause     (pause),
        .level_rst (reset_level_pulse),
        .overlap   (overlap_gated[KIND_BAD]),
        .allow     (fire[KIND_OBSTACLE]),
        .fire      (fire[KIND_BAD]),
        .pulse     (pulse[KIND_BAD])
    );

    collision_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_ch_bottom (
        .clk       (clk),
        .resetN    (resetN),
        .sof       (startOfFrame),
        .pause     (pause),
        .level_rst (reset_level_pulse),
        .overlap   (overlap_gated[KIND_BOTTOM]),
        .allow     (1'b1),
        .fire      (fire[KIND_BOTTOM]),
        .pulse     (pulse[KIND_BOTTOM])
    );

    collision_channel #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_ch_credit (
        .clk       (clk),
        .resetN    (resetN),
        .sof       (startOfFrame),
        .pause     (pause),
        .level_rst (reset_level_pulse),
        .overlap   (overlap_gated[KIND_CREDIT]),
        .allow     (1'b1),
        .fire      (fire[KIND_CREDIT]),
        .pulse     (pulse[KIND_CREDIT])
    );

    assign collisionBallObstacle     = pulse[KIND_OBSTACLE];
    assign collisionBallObstacleGood = pulse[KIND_GOOD];
    assign collisionBallObstacleBad  = pulse[KIND_BAD];
    assign collisionBallBottom       = pulse[KIND_BOTTOM];
    assign collisionBallCredit       = pulse[KIND_CREDIT];

endmodule

// File: tb/tb_collision_detector.sv
// tb/tb_collision_detector.sv - scoreboard bench for collision_detector
module tb_collision_detector;
    import defines::*;

`ifdef COLLISION_COOLDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif
    localparam int FRAME_LEN = 8;

    // request bits: [0] ball [1] obstacle [2] good [3] bad [4] bottom [5] credit
    localparam logic [5:0] R_NONE   = 6'b000000;
    localparam logic [5:0] R_OBS    = 6'b000011;
    localparam logic [5:0] R_GOOD   = 6'b000111;
    localparam logic [5:0] R_BAD    = 6'b001011;
    localparam logic [5:0] R_BOTTOM = 6'b010001;
    localparam logic [5:0] R_CREDIT = 6'b100001;
    localparam logic [5:0] R_MULTI  = 6'b110011;

    logic clk = 1'b0;
    logic resetN;
    logic startOfFrame, pause, reset_level_pulse;
    logic ballDrawingRequest, obstacleDrawingRequest, obstacleGoodRequest;
    logic obstacleBadRequest, bottomDrawingRequest, creditDrawingRequest;
    logic collisionBallObstacle, collisionBallObstacleGood, collisionBallObstacleBad;
    logic collisionBallBottom, collisionBallCredit;
    logic [4:0] out_vec;

    int checks = 0;
    int failures = 0;
    string cur_tag = "reset";

    logic [4:0] exp_q[$];
    bit         m_acc[5];
    int         m_cd[5];
    bit         m_seen;
    int         pulse_cnt[5];
    int         viol;

    logic       s_rstn, s_sof, s_pse, s_lvl;
    logic [5:0] s_req;

    always #5 clk = ~clk;

    assign out_vec = {collisionBallCredit, collisionBallBottom, collisionBallObstacleBad,
                      collisionBallObstacleGood, collisionBallObstacle};

    collision_detector dut (
        .clk                       (clk),
        .resetN                    (resetN),
        .startOfFrame              (startOfFrame),
        .pause                     (pause),
        .reset_level_pulse         (reset_level_pulse),
        .ballDrawingRequest        (ballDrawingRequest),
        .obstacleDrawingRequest    (obstacleDrawingRequest),
        .obstacleGoodRequest       (obstacleGoodRequest),
        .obstacleBadRequest        (obstacleBadRequest),
        .bottomDrawingRequest      (bottomDrawingRequest),
        .creditDrawingRequest      (creditDrawingRequest),
        .collisionBallObstacle     (collisionBallObstacle),
        .collisionBallObstacleGood (collisionBallObstacleGood),
        .collisionBallObstacleBad  (collisionBallObstacleBad),
        .collisionBallBottom       (collisionBallBottom),
        .collisionBallCredit       (collisionBallCredit)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_acc[k] = 1'b0;
            m_cd[k]  = 0;
        end
        m_seen = 1'b0;
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 5; k++) pulse_cnt[k] = 0;
        viol = 0;
    endtask

    // One clock: compare last edge's outputs, drive staged inputs, predict next edge
    task automatic tick();
        logic [4:0] exp;
        logic [4:0] ov;
        bit         obs_rep;
        bit         rep;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            chk_eq(cur_tag, 32'(out_vec), 32'(exp_q.pop_front()));
            for (int k = 0; k < 5; k++) if (out_vec[k]) pulse_cnt[k]++;
            if ((out_vec[1] || out_vec[2]) && !out_vec[0]) viol++;
        end
        resetN                 = s_rstn;
        startOfFrame           = s_sof;
        pause                  = s_pse;
        reset_level_pulse      = s_lvl;
        ballDrawingRequest     = s_req[0];
        obstacleDrawingRequest = s_req[1];
        obstacleGoodRequest    = s_req[2];
        obstacleBadRequest     = s_req[3];
        bottomDrawingRequest   = s_req[4];
        creditDrawingRequest   = s_req[5];

        ov[0] = s_req[0] & s_req[1];
        ov[1] = ov[0] & s_req[2];
        ov[2] = ov[0] & s_req[3];
        ov[3] = s_req[0] & s_req[4];
        ov[4] = s_req[0] & s_req[5];
        exp = '0;
        if (!s_rstn) begin
            model_reset();
        end else begin
            if (s_lvl) begin
                for (int k = 0; k < 5; k++) begin
                    m_acc[k] = 1'b0;
                    m_cd[k]  = 0;
                end
            end else if (s_pse) begin
                for (int k = 0; k < 5; k++) m_acc[k] = 1'b0;
            end else if (s_sof) begin
                obs_rep = m_acc[0] && (m_cd[0] == 0);
                for (int k = 0; k < 5; k++) begin
                    rep = m_acc[k] && (m_cd[k] == 0) && ((k == 1 || k == 2) ? obs_rep : 1'b1);
                    exp[k] = rep;
                    if (CD_EN) begin
                        if (rep) m_cd[k] = COOLDOWN_FRAMES;
                        else if (m_cd[k] > 0) m_cd[k] = m_cd[k] - 1;
                    end
                    m_acc[k] = ov[k];
                end
            end else begin
                for (int k = 0; k < 5; k++) if (m_seen && ov[k]) m_acc[k] = 1'b1;
            end
            if (s_sof) m_seen = 1'b1;
        end
        exp_q.push_back(exp);
    endtask

    task automatic run_frame(input logic [5:0] req, input int ov_start, input int ov_len,
                             input bit pse, input bit lvl_sof);
        for (int i = 0; i < FRAME_LEN; i++) begin
            s_sof = (i == 0);
            s_lvl = (i == 0) && lvl_sof;
            s_pse = pse;
            s_req = (i >= ov_start && i < ov_start + ov_len) ? req : R_NONE;
            tick();
            if (i == 0 && lvl_sof) begin
`ifdef COLLISION_COOLDOWN_EN
                @(posedge clk);
                #1;
                chk_eq("lvl_cooldown_zero", 32'(dut.u_ch_bottom.cooldown_q), 32'd0);
`endif
            end
        end
        s_sof = 1'b0;
        s_lvl = 1'b0;
        s_pse = 1'b0;
        s_req = R_NONE;
    endtask

    task automatic level_restart();
        s_sof = 1'b0;
        s_pse = 1'b0;
        s_req = R_NONE;
        s_lvl = 1'b1;
        tick();
        s_lvl = 1'b0;
        clr_cnt();
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0; pause = 1'b0; reset_level_pulse = 1'b0;
        ballDrawingRequest = 1'b0; obstacleDrawingRequest = 1'b0; obstacleGoodRequest = 1'b0;
        obstacleBadRequest = 1'b0; bottomDrawingRequest = 1'b0; creditDrawingRequest = 1'b0;
        s_rstn = 1'b0; s_sof = 1'b0; s_pse = 1'b0; s_lvl = 1'b0; s_req = R_NONE;
        model_reset();
        clr_cnt();

        cur_tag = "reset";
        repeat (3) tick();
        chk_eq("reset_outs", 32'(out_vec), 32'd0);
        s_rstn = 1'b1;

        cur_tag = "presync";
        s_req = R_CREDIT;
        repeat (4) tick();
        s_req = R_NONE;
        run_frame(R_NONE, 0, 0, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("presync_credit_cnt", pulse_cnt[4], 0);

        cur_tag = "credit3";
        level_restart();
        run_frame(R_CREDIT, 2, 3, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("credit3_cnt", pulse_cnt[4], 1);

        cur_tag = "sof_overlap";
        level_restart();
        run_frame(R_CREDIT, 0, 1, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("sof_overlap_cnt", pulse_cnt[4], 1);

        cur_tag = "good";
        level_restart();
        run_frame(R_GOOD, 3, 2, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("good_obs_cnt", pulse_cnt[0], 1);
        chk_eq("good_good_cnt", pulse_cnt[1], 1);
        chk_eq("good_bad_cnt", pulse_cnt[2], 0);

        cur_tag = "bad";
        level_restart();
        run_frame(R_BAD, 1, 4, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("bad_bad_cnt", pulse_cnt[2], 1);
        chk_eq("bad_good_cnt", pulse_cnt[1], 0);

        cur_tag = "multi";
        level_restart();
        run_frame(R_MULTI, 2, 2, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("multi_obs_cnt", pulse_cnt[0], 1);
        chk_eq("multi_bottom_cnt", pulse_cnt[3], 1);
        chk_eq("multi_credit_cnt", pulse_cnt[4], 1);

        cur_tag = "obs6";
        level_restart();
        repeat (6) run_frame(R_OBS, 2, 2, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("obs6_cnt", pulse_cnt[0], CD_EN ? 2 : 6);
        chk_eq("good_needs_obs", viol, 0);

        cur_tag = "pause";
        level_restart();
        run_frame(R_BOTTOM, 2, 3, 1, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("pause_bottom_cnt", pulse_cnt[3], 0);

        cur_tag = "pause_freeze";
        level_restart();
        run_frame(R_CREDIT, 2, 2, 0, 0);
        run_frame(R_CREDIT, 2, 2, 0, 0);
        run_frame(R_CREDIT, 2, 2, 1, 0);
        run_frame(R_CREDIT, 2, 2, 1, 0);
        repeat (4) run_frame(R_CREDIT, 2, 2, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("pause_freeze_cnt", pulse_cnt[4], CD_EN ? 2 : 5);

        cur_tag = "lvl_sof";
        level_restart();
        run_frame(R_BOTTOM, 2, 2, 0, 0);
        run_frame(R_BOTTOM, 2, 2, 0, 0);
        run_frame(R_BOTTOM, 2, 2, 0, 1);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("lvl_sof_bottom_cnt", pulse_cnt[3], 2);

        cur_tag = "async_rst";
        level_restart();
        run_frame(R_CREDIT, 2, 2, 0, 0);
        s_sof = 1'b1;
        s_req = R_BOTTOM;
        tick();
        s_sof = 1'b0;
        @(posedge clk);
        #2;
        chk_eq("pre_rst_credit", 32'(collisionBallCredit), 32'd1);
        resetN = 1'b0;
        #1;
        chk_eq("async_clear", 32'(out_vec), 32'd0);
        exp_q.delete();
        exp_q.push_back(5'b0);
        model_reset();
        clr_cnt();
        s_rstn = 1'b0;
        s_req = R_NONE;
        tick();
        tick();
        s_rstn = 1'b1;
        run_frame(R_NONE, 0, 0, 0, 0);
        run_frame(R_NONE, 0, 0, 0, 0);
        chk_eq("post_rst_bottom_cnt", pulse_cnt[3], 0);
        chk_eq("post_rst_credit_cnt", pulse_cnt[4], 0);

        cur_tag = "flush";
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
